// File: rtl/multi_chan_delay_pipe.sv
// ----------------------------------------------------------------------------
// multi_chan_delay_pipe
//
// NUM_CH independent delay lines, each DATA_W bits wide and DEPTH stages deep,
// with per-lane advance enables. A free-running counter drives a fault
// injector: when the counter equals SKIP_CYCLE (and SKIP_EN is set), every
// real lane is frozen for that cycle. A shadow copy of each lane advances on
// en_in alone and is compared against the real lane's last stage. Any
// difference latches a sticky per-lane mismatch flag. An instruction packet
// is also registered, with a one-cycle valid pulse after each capture.
//
// Ports:
//   clk           sole clock, all state on posedge
//   rst_n         asynchronous active-low reset
//   din           lane ch data at [ch*DATA_W +: DATA_W]
//   en_in         per-lane advance enable
//   dout          last real stage of each lane
//   inst_in       packed {instr[16:0], addr[9:0]}
//   inst_vld      capture strobe for inst_in
//   inst_q        last captured packet
//   inst_q_vld    high for the cycle after a capture
//   ctr           free-running cycle counter (wraps)
//   skip_pulse    high during the cycle whose edge is suppressed
//   clr_mismatch  synchronous clear of mismatch flags (wins over a set)
//   mismatch      sticky per-lane real/shadow divergence flags
// ----------------------------------------------------------------------------
module multi_chan_delay_pipe #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 1,
    parameter int DEPTH      = 1,
    parameter int CTR_W      = 11,
    parameter int SKIP_EN    = 1,
    parameter int SKIP_CYCLE = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATA_W-1:0]   din,
    input  logic [NUM_CH-1:0]          en_in,
    output logic [NUM_CH*DATA_W-1:0]   dout,
    input  logic [26:0]                inst_in,
    input  logic                       inst_vld,
    output logic [26:0]                inst_q,
    output logic                       inst_q_vld,
    output logic [CTR_W-1:0]           ctr,
    output logic                       skip_pulse,
    input  logic                       clr_mismatch,
    output logic [NUM_CH-1:0]          mismatch
);

    typedef struct packed {
        logic [16:0] instr;
        logic [9:0]  addr;
    } inst_pkt_t;

    localparam logic [CTR_W-1:0] LP_SKIP_AT = CTR_W'(SKIP_CYCLE);

    logic [CTR_W-1:0]  r_ctr;
    logic              w_skip;
    logic [NUM_CH-1:0] w_diff;
    logic [NUM_CH-1:0] r_mismatch;
    inst_pkt_t         r_inst;
    logic              r_inst_vld;

    // Free-running counter; natural wrap at 2**CTR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr <= '0;
        end else begin
            r_ctr <= r_ctr + CTR_W'(1);
        end
    end

    assign w_skip     = (SKIP_EN != 0) && (r_ctr == LP_SKIP_AT);
    assign skip_pulse = w_skip;
    assign ctr        = r_ctr;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        logic [DATA_W-1:0] r_real   [DEPTH];
        logic [DATA_W-1:0] r_shadow [DEPTH];
        logic              w_adv_real;

        // The real lane sees the injected fault; the shadow does not.
        assign w_adv_real = en_in[ch] && !w_skip;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_real[k] <= '0;
                end
            end else if (w_adv_real) begin
                r_real[0] <= din[ch*DATA_W +: DATA_W];
                for (int k = 1; k < DEPTH; k++) begin
                    r_real[k] <= r_real[k-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_shadow[k] <= '0;
                end
            end else if (en_in[ch]) begin
                r_shadow[0] <= din[ch*DATA_W +: DATA_W];
                for (int k = 1; k < DEPTH; k++) begin
                    r_shadow[k] <= r_shadow[k-1];
                end
            end
        end

        assign dout[ch*DATA_W +: DATA_W] = r_real[DEPTH-1];
        assign w_diff[ch]                = (r_real[DEPTH-1] != r_shadow[DEPTH-1]);
    end

    // Sticky flags; a clear in the same cycle as a new divergence wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch <= '0;
        end else if (clr_mismatch) begin
            r_mismatch <= '0;
        end else begin
            r_mismatch <= r_mismatch | w_diff;
        end
    end

    assign mismatch = r_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst     <= '0;
            r_inst_vld <= 1'b0;
        end else begin
            r_inst_vld <= inst_vld;
            if (inst_vld) begin
                r_inst <= inst_pkt_t'(inst_in);
            end
        end
    end

    assign inst_q     = r_inst;
    assign inst_q_vld = r_inst_vld;

endmodule

// File: tb/tb_multi_chan_delay_pipe.sv
// ----------------------------------------------------------------------------
// tb_multi_chan_delay_pipe
//
// Two instances share clk/rst_n:
//   u_dut  : default parameters (4 lanes x 1 bit, depth 1, skip at ctr==40)
//   u_dut2 : 2 lanes x 8 bits, depth 3, fault injection disabled
// Directed stimulus with hand-computed expectations, one checking task.
// ----------------------------------------------------------------------------
module tb_multi_chan_delay_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  din, en_in, dout, mismatch;
    logic [26:0] inst_in, inst_q;
    logic        inst_vld, inst_q_vld, skip_pulse, clr;
    logic [10:0] ctr;

    logic [15:0] din2, dout2;
    logic [1:0]  en2, mm2;
    logic [26:0] inst_in2, inst_q2;
    logic        inst_vld2, inst_q_vld2, skip2, clr2;
    logic [10:0] ctr2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    multi_chan_delay_pipe u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .en_in        (en_in),
        .dout         (dout),
        .inst_in      (inst_in),
        .inst_vld     (inst_vld),
        .inst_q       (inst_q),
        .inst_q_vld   (inst_q_vld),
        .ctr          (ctr),
        .skip_pulse   (skip_pulse),
        .clr_mismatch (clr),
        .mismatch     (mismatch)
    );

    multi_chan_delay_pipe #(
        .NUM_CH (2),
        .DATA_W (8),
        .DEPTH  (3),
        .SKIP_EN(0)
    ) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din2),
        .en_in        (en2),
        .dout         (dout2),
        .inst_in      (inst_in2),
        .inst_vld     (inst_vld2),
        .inst_q       (inst_q2),
        .inst_q_vld   (inst_q_vld2),
        .ctr          (ctr2),
        .skip_pulse   (skip2),
        .clr_mismatch (clr2),
        .mismatch     (mm2)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = (cyc + 1) % 2048;
    endtask

    // Lane pattern: toggle every cycle, except at ctr 40 only lane 2 differs
    // from the value driven at ctr 39 (4'hF -> 4'hB).
    function automatic logic [3:0] pat_a(input int c);
        if (c == 40) return 4'hB;
        return (c % 2 == 1) ? 4'hF : 4'h0;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp0 [10];
        logic [7:0] e1;
        int         wraps;
        int         k;
        logic [10:0] prev;

        exp0 = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h04, 8'h05, 8'h08};

        rst_n = 1'b0; din = '0; en_in = '0; inst_in = '0; inst_vld = 1'b0; clr = 1'b0;
        din2 = '0; en2 = '0; inst_in2 = '0; inst_vld2 = 1'b0; clr2 = 1'b0;

        // Reset state
        step(); step();
        check_val("rst_dout",     64'(dout), 64'h0);
        check_val("rst_ctr",      64'(ctr), 64'h0);
        check_val("rst_mismatch", 64'(mismatch), 64'h0);
        check_val("rst_inst_q",   64'(inst_q), 64'h0);
        check_val("rst_inst_vld", 64'(inst_q_vld), 64'h0);
        check_val("rst_dout2",    64'(dout2), 64'h0);
        check_val("rst_ctr2",     64'(ctr2), 64'h0);
        check_val("rst_mm2",      64'(mm2), 64'h0);
        check_val("rst_inst_q2",  64'(inst_q2), 64'h0);
        check_val("rst_inst_v2",  64'(inst_q_vld2), 64'h0);
        rst_n = 1'b1;
        cyc   = 0;

        // Skip at ctr 40 freezes real lanes; only lane 2 diverges
        en_in = 4'hF;
        for (int c = 0; c < 46; c++) begin
            din = pat_a(c);
            check_val("A_ctr",  64'(ctr), 64'(c));
            check_val("A_skip", 64'(skip_pulse), 64'(c == 40));
            step();
            check_val("A_dout", 64'(dout), 64'((c == 40) ? pat_a(39) : pat_a(c)));
            check_val("A_mismatch", 64'(mismatch), 64'((c + 1 >= 42) ? 4'h4 : 4'h0));
        end

        // Clear pulse
        clr = 1'b1;
        step();
        check_val("B_clr", 64'(mismatch), 64'h0);
        clr = 1'b0;
        step();
        check_val("B_after_clr", 64'(mismatch), 64'h0);

        // Instruction packet capture
        inst_in  = {17'h1ABCD, 10'd5};
        inst_vld = 1'b1;
        step();
        check_val("C_q1",   64'(inst_q), 64'h6AF3405);
        check_val("C_vld1", 64'(inst_q_vld), 64'h1);
        inst_vld = 1'b0;
        inst_in  = 27'h7FFFFFF;
        step();
        check_val("C_hold", 64'(inst_q), 64'h6AF3405);
        check_val("C_vld0", 64'(inst_q_vld), 64'h0);
        inst_in  = {17'h00012, 10'h3FF};
        inst_vld = 1'b1;
        step();
        check_val("C_q2",   64'(inst_q), 64'h0004BFF);
        check_val("C_vld2", 64'(inst_q_vld), 64'h1);
        inst_in  = {17'h1FFFF, 10'd0};
        step();
        check_val("C_q3",   64'(inst_q), 64'h7FFFC00);
        check_val("C_vld3", 64'(inst_q_vld), 64'h1);
        inst_vld = 1'b0;
        step();
        check_val("C_vld_end", 64'(inst_q_vld), 64'h0);
        check_val("C_q_end",   64'(inst_q), 64'h7FFFC00);

        // Depth-3 lane latency with a 2-cycle enable hold
        for (int j = 1; j <= 10; j++) begin
            din2 = {8'hC3, 8'(j)};
            en2  = (j == 6 || j == 7) ? 2'b00 : 2'b11;
            e1   = (j >= 3) ? 8'hC3 : 8'h00;
            step();
            check_val("D_dout2", 64'(dout2), 64'({e1, exp0[j-1]}));
            check_val("D_mm2",   64'(mm2), 64'h0);
        end

        // Long run: random traffic on u_dut2, counter wrap, second skip on u_dut
        wraps = 0;
        for (int i = 0; i < 3000; i++) begin
            din2  = 16'($urandom);
            en2   = 2'($urandom_range(0, 3));
            din   = (cyc == 40) ? 4'hB : 4'hF;
            prev  = ctr;
            step();
            if (prev == 11'd2047 && ctr == 11'd0) wraps++;
        end
        check_val("E_wraps", 64'(wraps), 64'd1);
        check_val("E_ctr",   64'(ctr), 64'(cyc));
        check_val("E_ctr2",  64'(ctr2), 64'(cyc));
        check_val("E_mismatch", 64'(mismatch), 64'h4);
        check_val("E_mm2",   64'(mm2), 64'h0);
        check_val("E_skip2", 64'(skip2), 64'h0);

        // Asynchronous reset mid-traffic at ctr 20
        din = 4'hF;
        k   = 0;
        while (cyc != 20 && k < 2100) begin
            step();
            k++;
        end
        check_val("F_ctr_pre",  64'(ctr), 64'd20);
        check_val("F_dout_pre", 64'(dout), 64'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("F_dout",     64'(dout), 64'h0);
        check_val("F_ctr",      64'(ctr), 64'h0);
        check_val("F_mismatch", 64'(mismatch), 64'h0);
        check_val("F_inst_q",   64'(inst_q), 64'h0);
        check_val("F_ctr2",     64'(ctr2), 64'h0);
        step();
        rst_n = 1'b1;
        cyc   = 0;

        // Skip recurs 40 cycles after release; clear held over the divergence
        clr = 1'b1;
        for (int c = 0; c < 46; c++) begin
            din = pat_a(c);
            check_val("G_ctr",  64'(ctr), 64'(c));
            check_val("G_skip", 64'(skip_pulse), 64'(c == 40));
            step();
            check_val("G_mismatch", 64'(mismatch), 64'h0);
        end
        clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_chan_delay_pipe.md
Name: multi_chan_delay_pipe

Overview:
Parametrised successor to the single-bit registered pass-through block. It provides NUM_CH independent delay lines, each DATA_W bits wide and DEPTH stages deep, with per-channel enables. A programmable fault-injection cycle freezes all lanes for one cycle. A shadow pipeline, which ignores the fault, self-checks each lane and raises sticky mismatch flags. It also registers an instruction packet (17-bit instr, 10-bit addr) with a valid strobe, so GPI tests get a struct-carrying sequential path.

Parameters:
NUM_CH, 4, number of independent lanes (>=1)
DATA_W, 1, bits per lane (>=1)
DEPTH, 1, pipeline stages per lane (>=1)
CTR_W, 11, width of free-running cycle counter
SKIP_EN, 1, 1 = fault injection active, 0 = never skip
SKIP_CYCLE, 40, counter value at which the skip occurs (< 2**CTR_W)

Ports:
clk  input  1  sole clock, all state on posedge
rst_n  input  1  asynchronous, active-low reset
din  input  NUM_CH*DATA_W  lane ch occupies bits [ch*DATA_W +: DATA_W]
en_in  input  NUM_CH  per-lane advance enable
dout  output  NUM_CH*DATA_W  last stage of each real lane
inst_in  input  27  packed {instr[16:0], addr[9:0]}
inst_vld  input  1  capture strobe for inst_in
inst_q  output  27  last captured packet
inst_q_vld  output  1  one-cycle pulse, cycle after capture
ctr  output  CTR_W  free-running cycle counter
skip_pulse  output  1  high during the cycle whose edge is suppressed
clr_mismatch  input  1  synchronous clear of mismatch flags
mismatch  output  NUM_CH  sticky per-lane self-check failure

Behaviour:
- Reset (rst_n low, async): all real and shadow stages 0; dout 0; ctr 0; inst_q 0; inst_q_vld 0; mismatch 0. Release takes effect on the first posedge with rst_n high.
- ctr: +1 every clock and wraps from 2**CTR_W-1 to 0. No enable.
- skip_pulse = SKIP_EN && (ctr == SKIP_CYCLE). Combinational from ctr and repeats every wrap.
- Real lane ch advances iff en_in[ch] && !skip_pulse. Advance means stage0 <= din lane slice and stage k <= stage k-1. A non-advancing lane holds all stages.
- Shadow lane ch advances iff en_in[ch]; it ignores skip.
- dout lane = real stage DEPTH-1. Latency with en held high and no skip: DEPTH cycles, din at edge n appears on dout after edge n+DEPTH-1.
- Checker: each cycle, if real last stage != shadow last stage for lane ch, mismatch[ch] <= 1 at the next edge. The flag is sticky.
- clr_mismatch high: mismatch <= 0 at the edge. The clear wins over a simultaneous set in the same cycle.
- Packet: inst_vld high at edge n gives inst_q <= inst_in and inst_q_vld = 1 for the cycle after edge n. inst_q holds otherwise. Back-to-back strobes give a continuous inst_q_vld with each packet captured.
- Skip and en_in low in the same cycle: the lane holds (same effect). The shadow also holds, so no divergence.
- A skip with din constant across the frozen window produces no mismatch. The checker detects data divergence only, not timing.
- Reset mid-operation: all state clears immediately. ctr restarts from 0, so the skip recurs SKIP_CYCLE cycles after release.
- SKIP_EN=0: real and shadow are identical, and mismatch never sets.

Test Plan:
- Defaults, en_in=4'hF, din lanes toggled each cycle -> dout = din delayed 1 cycle. skip_pulse high only at ctr==40, when dout holds. mismatch sets only on lanes whose din changed at that edge, one cycle after the divergence becomes visible.
- DEPTH=3, DATA_W=8, lane0 din = 8'h01,8'h02,... -> dout lane0 = 8'h01 three edges after first drive. en_in[0] low for 2 cycles inserts a 2-cycle hold with no mismatch.
- SKIP_EN=0, 3000 cycles of random din/en_in -> mismatch stays 0. ctr wraps 2047->0 exactly once, at cycle 2048.
- mismatch set on lane2, then clr_mismatch pulsed -> mismatch[2]=0 next cycle. clr held while a new divergence occurs -> flag stays 0.
- inst_in={17'h1ABCD,10'd5} with inst_vld for 1 cycle -> inst_q equals the packet and inst_q_vld=1 for exactly one cycle. Two consecutive strobes -> inst_q_vld high 2 cycles, inst_q updates twice.
- rst_n asserted at ctr==20 mid-traffic -> dout, ctr, mismatch and inst_q all 0 without waiting for clk. After release, the skip occurs 40 cycles later.
